// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the loader's byte-stream handshake and instruction-memory write bus.
//   in_valid / in_data / in_ready   : big-endian byte stream, valid/ready handshake
//   imem_we / imem_addr / imem_wdata: one-cycle word write into instruction memory
// master : the side that feeds bytes and observes the memory writes (testbench / host)
// slave  : the loader itself
interface imem_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
// Program loader for the CPU instruction memory. Packs a big-endian byte stream
// four bytes at a time into 32-bit words and writes them to consecutive word
// addresses starting at 0, holding the CPU stalled until the image is complete.
//
// Ports:
//   clock     : single clock, all state changes on posedge
//   reset_n   : asynchronous active-low reset
//   start     : one-cycle pulse, accepted only in IDLE, DONE or ERROR
//   len       : number of words to load, sampled with an accepted start
//   bus       : imem_loader_if.slave (byte stream in, instruction-memory write out)
//   cpu_hold  : CPU stall, low only in DONE
//   busy      : load in progress
//   done      : last load completed successfully (level)
//   error     : last load failed (level)
//
// Optional feature: define IMEM_LOAD_CHECKSUM_EN to append one checksum byte to
// every load; the 8-bit sum of all data bytes plus that byte must be zero.
module imem_loader #(
   parameter int ADDR_W = 10
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   input  logic [ADDR_W:0] len,
   imem_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            busy,
   output logic            done,
   output logic            error
);

   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      DONE,
`ifdef IMEM_LOAD_CHECKSUM_EN
      ERROR,
      CHECK
`else
      ERROR
`endif
   } state_t;

   state_t            state;
   state_t            next_state;
   logic              start_ok;
   logic              in_ready_c;
   logic              byte_acc;
   logic [1:0]        byte_cnt;
   logic [23:0]       asm_reg;
   logic [ADDR_W:0]   word_idx;
   logic [ADDR_W:0]   len_reg;
   logic              final_pending;
   logic              imem_we_r;
   logic [ADDR_W-1:0] imem_addr_r;
   logic [31:0]       imem_wdata_r;
`ifdef IMEM_LOAD_CHECKSUM_EN
   logic [7:0]        sum;
   logic [7:0]        check_total;

   assign check_total = sum + bus.in_data;
`endif

   assign byte_acc = bus.in_valid & in_ready_c;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake decode. in_ready drops while the final word of
   // the image is being written so no extra byte slips in after it.
   always_comb begin
      next_state = state;
      start_ok   = 1'b0;
      in_ready_c = 1'b0;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start) begin
               start_ok = 1'b1;
               if (len == '0) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                  next_state = CHECK;
`else
                  next_state = DONE;
`endif
               end else if (len > MAX_LEN) begin
                  next_state = ERROR;
               end else begin
                  next_state = LOAD;
               end
            end
         end
         LOAD: begin
            in_ready_c = ~final_pending;
            if (final_pending) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
               next_state = CHECK;
`else
               next_state = DONE;
`endif
            end
         end
`ifdef IMEM_LOAD_CHECKSUM_EN
         CHECK: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               next_state = (check_total == 8'h00) ? DONE : ERROR;
            end
         end
`endif
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Byte assembly and word write. The first three bytes of a word collect in
   // asm_reg; the fourth goes straight into the write data so the word is
   // presented the cycle after its last byte is accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byte_cnt      <= '0;
         asm_reg       <= '0;
         word_idx      <= '0;
         len_reg       <= '0;
         final_pending <= 1'b0;
         imem_we_r     <= 1'b0;
         imem_addr_r   <= '0;
         imem_wdata_r  <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
         sum           <= '0;
`endif
      end else begin
         imem_we_r     <= 1'b0;
         final_pending <= 1'b0;
         if (start_ok) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len_reg  <= len;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum      <= '0;
`endif
         end else if (byte_acc && (state == LOAD)) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum      <= sum + bus.in_data;
`endif
            if (byte_cnt == 2'd3) begin
               imem_we_r     <= 1'b1;
               imem_addr_r   <= word_idx[ADDR_W-1:0];
               imem_wdata_r  <= {asm_reg, bus.in_data};
               word_idx      <= word_idx + 1'b1;
               final_pending <= ((word_idx + 1'b1) == len_reg);
            end else begin
               asm_reg <= {asm_reg[15:0], bus.in_data};
            end
         end
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.imem_we    = imem_we_r;
   assign bus.imem_addr  = imem_addr_r;
   assign bus.imem_wdata = imem_wdata_r;

`ifdef IMEM_LOAD_CHECKSUM_EN
   assign busy = (state == LOAD) || (state == CHECK);
`else
   assign busy = (state == LOAD);
`endif
   assign cpu_hold = (state != DONE);
   assign done     = (state == DONE);
   assign error    = (state == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Directed testbench for imem_loader. Expected memory writes are queued as the
// stimulus is issued; a monitor process pops and compares on every imem_we.
// Status levels are compared directly at the clock's falling edge.
// Builds with or without IMEM_LOAD_CHECKSUM_EN.
module tb_imem_loader;
   localparam int ADDR_W = 10;

   logic            clock   = 1'b0;
   logic            reset_n = 1'b0;
   logic            start   = 1'b0;
   logic [ADDR_W:0] len     = '0;
   logic            cpu_hold;
   logic            busy;
   logic            done;
   logic            error;

   int vectors = 0;
   int fails   = 0;
   logic [ADDR_W+31:0] exp_q[$];

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .len      (len),
      .bus      (bus),
      .cpu_hold (cpu_hold),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clock = ~clock;

   // Generic compare: counts the vector and reports a failure line.
   task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   // Pops the expected write for every strobe seen outside reset.
   task automatic monitor_loop();
      logic [ADDR_W+31:0] e;
      forever begin
         @(negedge clock);
         if (reset_n && bus.imem_we) begin
            if (exp_q.size() == 0) begin
               vectors++;
               fails++;
               $display("[TB] FAIL unexpected_write got addr %0d data %h expected no write",
                        bus.imem_addr, bus.imem_wdata);
            end else begin
               e = exp_q.pop_front();
               check_output("imem_write", {bus.imem_addr, bus.imem_wdata}, e);
            end
         end
      end
   endtask

   // Holds a byte valid until accepted; returns just after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int waited;
      waited       = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      @(negedge clock);
      while (!bus.in_ready && waited < 50) begin
         waited++;
         @(negedge clock);
      end
      if (!bus.in_ready) begin
         vectors++;
         fails++;
         $display("[TB] FAIL in_ready_timeout got in_ready=0 expected 1 within 50 cycles");
      end
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Sends n bytes (MSB first) from a packed vector, optionally idling a
   // cycle between bytes.
   task automatic apply_stimulus(input logic [63:0] bytes, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         send_byte(bytes[8*(n-1-i) +: 8]);
         if (gaps && (i != n - 1)) begin
            @(posedge clock);
            #1;
         end
      end
   endtask

   task automatic pulse_start(input logic [ADDR_W:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   // Start a non-empty load and confirm LOAD is entered the next cycle.
   task automatic begin_load(input logic [ADDR_W:0] l, input string name);
      pulse_start(l);
      @(negedge clock);
      check_output({name, "_enter_load"}, {bus.in_ready, busy, cpu_hold, done}, 4'b1110);
      @(posedge clock);
      #1;
   endtask

   // Called in the cycle of the final write; confirms in_ready dropped, then
   // (with checksum) sends the checksum byte, then confirms DONE.
   task automatic expect_done(input logic [7:0] cks, input string name);
      @(negedge clock);
      check_output({name, "_last_write_cycle"}, {bus.in_ready, done, busy}, 3'b001);
`ifdef IMEM_LOAD_CHECKSUM_EN
      @(posedge clock);
      #1;
      send_byte(cks);
`else
      if (cks == 8'hFF) $display("[TB] checksum byte unused in this build");
`endif
      @(negedge clock);
      check_output({name, "_done"}, {done, cpu_hold, busy, error}, 4'b1000);
      @(posedge clock);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      fork
         monitor_loop();
      join_none

      // Reset values
      repeat (2) @(negedge clock);
      check_output("reset_levels", {bus.in_ready, bus.imem_we, cpu_hold, busy, done, error}, 6'b001000);
      check_output("reset_addr", bus.imem_addr, 0);
      check_output("reset_wdata", bus.imem_wdata, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Two-word load, continuous stream
      $display("[TB] len=2 continuous stream");
      exp_q.push_back({10'd0, 32'h2009000F});
      exp_q.push_back({10'd1, 32'h200A0007});
      begin_load(11'd2, "cont");
      apply_stimulus(64'h2009000F200A0007, 8, 1'b0);
      expect_done(8'h97, "cont");

      // Same stream with in_valid toggling; start from DONE restarts at addr 0
      $display("[TB] len=2 gapped stream");
      exp_q.push_back({10'd0, 32'h2009000F});
      exp_q.push_back({10'd1, 32'h200A0007});
      begin_load(11'd2, "gap");
      apply_stimulus(64'h2009000F200A0007, 8, 1'b1);
      expect_done(8'h97, "gap");

      // Empty load
      $display("[TB] len=0");
      pulse_start(11'd0);
      @(negedge clock);
`ifdef IMEM_LOAD_CHECKSUM_EN
      check_output("len0_check", {busy, bus.in_ready, done}, 3'b110);
      @(posedge clock);
      #1;
      send_byte(8'h00);
      @(negedge clock);
`endif
      check_output("len0_done", {done, error, cpu_hold, busy}, 4'b1000);
      @(posedge clock);
      #1;

      // Oversized load
      $display("[TB] len=1025");
      pulse_start(11'd1025);
      @(negedge clock);
      check_output("len_over_error", {done, error, cpu_hold, busy, bus.in_ready}, 5'b01100);
      repeat (3) @(posedge clock);
      #1;

      // Reset after six bytes, then a fresh one-word load
      $display("[TB] reset mid-load");
      exp_q.push_back({10'd0, 32'h2009000F});
      begin_load(11'd2, "rst");
      apply_stimulus(64'h2009000F200A, 6, 1'b0);
      reset_n = 1'b0;
      @(negedge clock);
      check_output("midload_reset_levels", {bus.in_ready, bus.imem_we, cpu_hold, busy, done, error}, 6'b001000);
      check_output("midload_reset_wdata", bus.imem_wdata, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      exp_q.push_back({10'd0, 32'h00000000});
      begin_load(11'd1, "reload");
      apply_stimulus(64'h0, 4, 1'b0);
      expect_done(8'h00, "reload");

      // Start pulses during a load are ignored
      $display("[TB] start while busy");
      exp_q.push_back({10'd0, 32'h11223344});
      exp_q.push_back({10'd1, 32'h55667788});
      begin_load(11'd2, "busy");
      apply_stimulus(64'h112233, 3, 1'b0);
      start = 1'b1;
      len   = 11'd1;
      send_byte(8'h44);
      start = 1'b0;
      apply_stimulus(64'h5566, 2, 1'b0);
      start = 1'b1;
      len   = 11'd0;
      send_byte(8'h77);
      start = 1'b0;
      send_byte(8'h88);
      expect_done(8'h9C, "busy");

`ifdef IMEM_LOAD_CHECKSUM_EN
      // Checksum pass and fail
      $display("[TB] checksum pass/fail");
      exp_q.push_back({10'd0, 32'h01020304});
      begin_load(11'd1, "cks_pass");
      apply_stimulus(64'h01020304, 4, 1'b0);
      expect_done(8'hF6, "cks_pass");

      exp_q.push_back({10'd0, 32'h01020304});
      begin_load(11'd1, "cks_fail");
      apply_stimulus(64'h01020304, 4, 1'b0);
      @(negedge clock);
      @(posedge clock);
      #1;
      send_byte(8'hF5);
      @(negedge clock);
      check_output("cks_fail_error", {done, error, cpu_hold, busy}, 4'b0110);
      @(posedge clock);
      #1;
`endif

      repeat (2) @(negedge clock);
      check_output("all_writes_seen", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
